// File: rtl/l0ringer_pkg.sv
// Shared types for the L0 ringer event path (event_loader / tower_builder).
package l0ringer_pkg;
  localparam int MEMORY_ADDR_LENGTH_DEF = 20;
  localparam int CELL_WIDTH_DEF         = 32;

  // One calorimeter cell record, one event-memory word.
  typedef struct packed {
    logic [15:0] energy;
    logic [3:0]  layer;
    logic [5:0]  eta;
    logic [5:0]  phi;
  } cell_t;

  // Closed-event window; len is one bit wider so a full-depth event fits.
  typedef struct packed {
    logic [MEMORY_ADDR_LENGTH_DEF-1:0] bottom;
    logic [MEMORY_ADDR_LENGTH_DEF-1:0] top;
    logic [MEMORY_ADDR_LENGTH_DEF:0]   len;
  } event_desc_t;
endpackage

// File: rtl/event_desc_fifo.sv
// Show-ahead synchronous FIFO of event descriptors.
module event_desc_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = l0ringer_pkg::event_desc_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  T                       din,
  output T                       head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  T            mem_q [DEPTH];
  logic [AW:0] wp_q, rp_q;
  logic        full, do_push, do_pop;

  assign count   = wp_q - rp_q;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rp_q[AW-1:0]];

  // Storage and pointers; storage is cleared so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wp_q[AW-1:0]] <= din;
        wp_q <= wp_q + 1'b1;
      end
      if (do_pop) rp_q <= rp_q + 1'b1;
    end
  end
endmodule

// File: rtl/event_loader.sv
// Writes per-event cell streams into the ring-buffer event memory and
// presents closed event windows to tower_builder.
module event_loader #(
  parameter int MEMORY_ADDR_LENGTH = l0ringer_pkg::MEMORY_ADDR_LENGTH_DEF,
  parameter int CELL_WIDTH         = l0ringer_pkg::CELL_WIDTH_DEF,
  parameter int EVT_FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [CELL_WIDTH-1:0]         s_data,
  input  logic                          s_last,
  output logic                          mem_we,
  output logic [MEMORY_ADDR_LENGTH-1:0] mem_waddr,
  output logic [CELL_WIDTH-1:0]         mem_wdata,
  output logic                          ev_valid,
  output logic [MEMORY_ADDR_LENGTH-1:0] bottom_addr,
  output logic [MEMORY_ADDR_LENGTH-1:0] top_addr,
  input  logic                          event_done,
  output logic                          overflow
);
  import l0ringer_pkg::*;

  localparam int AW  = MEMORY_ADDR_LENGTH;
  localparam int FCW = $clog2(EVT_FIFO_DEPTH) + 1;
  localparam logic [AW:0] DEPTH_W = {1'b1, {AW{1'b0}}};

  typedef struct packed {
    logic [AW-1:0] bottom;
    logic [AW-1:0] top;
    logic [AW:0]   len;
  } desc_t;

  typedef enum logic [1:0] {IDLE, OPEN, DROP} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, ev_start_q, ev_start_d;
  logic [AW:0]      used_q, used_d, cnt_q, cnt_d;
  logic             push_q, push_d;
  desc_t            pdesc_q, pdesc_d;
  logic             ovf_q, ovf_d, we_q, we_d;
  logic [AW-1:0]    waddr_q, waddr_d;
  logic [CELL_WIDTH-1:0] wdata_q, wdata_d;

  desc_t            head;
  logic             fifo_empty;
  logic [FCW-1:0]   fifo_cnt;
  logic             mem_full, fifo_full, fifo_idle, acc, pop, oversize;

  // The descriptor of a just-closed event is pushed one cycle late (after its
  // last word is written), so fullness counts that pending push as occupied.
  assign mem_full  = (used_q == DEPTH_W);
  assign fifo_full = ({1'b0, fifo_cnt} + {{FCW{1'b0}}, push_q}) >= (FCW+1)'(EVT_FIFO_DEPTH);
  assign fifo_idle = fifo_empty && !push_q;
  assign s_ready   = (state_q == DROP) || (!mem_full && !fifo_full);
  assign acc       = s_valid && s_ready;
  assign pop       = event_done && !fifo_empty;
  // Open event already owns the whole memory: it can never complete.
  assign oversize  = (state_q == OPEN) && mem_full && fifo_idle;

  // Next-state: event FSM, ring pointers, occupancy and write port.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    ev_start_d = ev_start_q;
    cnt_d      = cnt_q;
    used_d     = used_q;
    push_d     = 1'b0;
    pdesc_d    = pdesc_q;
    ovf_d      = ovf_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    if (pop) used_d = used_q - head.len;
    if (oversize) begin
      state_d  = DROP;
      ovf_d    = 1'b1;
      wr_ptr_d = ev_start_q;
      used_d   = '0;
    end else if (acc && state_q == DROP) begin
      if (s_last) state_d = IDLE;
    end else if (acc) begin
      we_d     = 1'b1;
      waddr_d  = wr_ptr_q;
      wdata_d  = s_data;
      wr_ptr_d = wr_ptr_q + 1'b1;
      used_d   = used_d + 1'b1;
      if (state_q == IDLE) begin
        ev_start_d = wr_ptr_q;
        cnt_d      = (AW+1)'(1);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      if (s_last) begin
        push_d  = 1'b1;
        pdesc_d = '{bottom: (state_q == IDLE) ? wr_ptr_q : ev_start_q,
                    top:    wr_ptr_q,
                    len:    cnt_d};
        state_d = IDLE;
      end else begin
        state_d = OPEN;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      ev_start_q <= '0;
      cnt_q      <= '0;
      used_q     <= '0;
      push_q     <= 1'b0;
      pdesc_q    <= '0;
      ovf_q      <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      ev_start_q <= ev_start_d;
      cnt_q      <= cnt_d;
      used_q     <= used_d;
      push_q     <= push_d;
      pdesc_q    <= pdesc_d;
      ovf_q      <= ovf_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  event_desc_fifo #(.DEPTH(EVT_FIFO_DEPTH), .T(desc_t)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_q),
    .pop   (pop),
    .din   (pdesc_q),
    .head  (head),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign mem_we      = we_q;
  assign mem_waddr   = waddr_q;
  assign mem_wdata   = wdata_q;
  assign ev_valid    = !fifo_empty;
  assign bottom_addr = head.bottom;
  assign top_addr    = head.top;
  assign overflow    = ovf_q;
endmodule

// File: tb/tb_event_loader.sv
// Directed bench for event_loader with a transaction-level reference model.
module tb_event_loader;
  localparam int AW = 4, DEP = 16, CW = 32, FD = 4;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          s_valid = 1'b0, s_last = 1'b0, event_done = 1'b0;
  logic [CW-1:0] s_data = '0;
  logic          s_ready, mem_we, ev_valid, overflow;
  logic [AW-1:0] mem_waddr, bottom_addr, top_addr;
  logic [CW-1:0] mem_wdata;

  always #5 clk = ~clk;

  event_loader #(.MEMORY_ADDR_LENGTH(AW), .CELL_WIDTH(CW), .EVT_FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .ev_valid(ev_valid), .bottom_addr(bottom_addr), .top_addr(top_addr),
    .event_done(event_done), .overflow(overflow)
  );

  int nchk = 0, nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Events are tracked as a queue of closed windows; each becomes visible two
  // cycles after its last-cell handshake and leaves on an event_done.
  typedef struct { int bottom; int top; int len; int vis; } ev_t;
  ev_t         evq[$];
  int          wlog[$];
  int          cyc, m_wr, m_used, m_start, m_cnt, e_addr;
  bit          m_open, m_drop, m_ovf, e_we;
  logic [CW-1:0] e_data;
  bit          rdy, pres, hs, pop;

  function automatic void m_reset();
    evq.delete();
    cyc = 0; m_wr = 0; m_used = 0; m_start = 0; m_cnt = 0;
    m_open = 0; m_drop = 0; m_ovf = 0; e_we = 0; e_addr = 0; e_data = '0;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) m_reset();
    else begin
      rdy  = m_drop || (m_used < DEP && evq.size() < FD);
      pres = (evq.size() > 0) && (evq[0].vis <= cyc);
      chk("s_ready", s_ready, rdy);
      chk("ev_valid", ev_valid, pres);
      if (pres) begin
        chk("bottom_addr", bottom_addr, evq[0].bottom);
        chk("top_addr", top_addr, evq[0].top);
      end
      chk("overflow", overflow, m_ovf);
      chk("mem_we", mem_we, e_we);
      if (e_we) begin
        chk("mem_waddr", mem_waddr, e_addr);
        chk("mem_wdata", mem_wdata, e_data);
      end
      if (mem_we) wlog.push_back(int'(mem_waddr));
      hs  = s_valid && rdy;
      pop = event_done && pres;
      e_we = 0;
      if (m_open && m_used == DEP && evq.size() == 0) begin
        m_drop = 1; m_ovf = 1; m_open = 0; m_wr = m_start; m_used = 0;
      end else if (hs && m_drop) begin
        if (s_last) m_drop = 0;
      end else if (hs) begin
        e_we = 1; e_addr = m_wr; e_data = s_data;
        if (!m_open) begin m_start = m_wr; m_cnt = 0; end
        m_cnt++; m_used++;
        if (s_last) begin
          evq.push_back('{bottom: m_start, top: m_wr, len: m_cnt, vis: cyc + 2});
          m_open = 0;
        end else m_open = 1;
        m_wr = (m_wr + 1) % DEP;
      end
      if (pop) begin m_used -= evq[0].len; evq.pop_front(); end
      cyc++;
    end
  end

  // ---------------- stimulus helpers ----------------
  int dcnt = 0;

  task automatic send(input bit last);
    int n = 0;
    @(posedge clk); #1;
    s_valid = 1'b1; s_last = last; s_data = 32'hCE11_0000 + dcnt; dcnt++;
    @(negedge clk);
    while (!s_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      nchk++; nerr++;
      $display("FAIL send_timeout: s_ready stayed %0b, required 1", s_ready);
    end
  endtask

  task automatic send_evt(input int n);
    for (int i = 0; i < n; i++) send(i == n - 1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_done();
    @(posedge clk); #1 event_done = 1'b1;
    @(posedge clk); #1 event_done = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_ready"}, s_ready, 1);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_waddr"}, mem_waddr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_ev_valid"}, ev_valid, 0);
    chk({tag, "_bottom"}, bottom_addr, 0);
    chk({tag, "_top"}, top_addr, 0);
    chk({tag, "_overflow"}, overflow, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc_cnt, k, base;
    #2 chk_reset_vals("rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // single 3-cell event at 0
    send_evt(3);
    wait_neg(3);
    chk("single_ev_valid", ev_valid, 1);
    chk("single_bottom", bottom_addr, 0);
    chk("single_top", top_addr, 2);
    chk("single_nwrites", wlog.size(), 3);
    chk("single_w0", wlog[0], 0);
    chk("single_w2", wlog[2], 2);
    pulse_done();
    wait_neg(1);
    chk("single_done_ev_valid", ev_valid, 0);

    // advance to 14, then a 4-cell wrapping event
    send_evt(11);
    wait_neg(3);
    pulse_done();
    send_evt(4);
    wait_neg(3);
    chk("wrap_bottom", bottom_addr, 14);
    chk("wrap_top", top_addr, 1);
    chk("wrap_w0", wlog[wlog.size()-4], 14);
    chk("wrap_w1", wlog[wlog.size()-3], 15);
    chk("wrap_w2", wlog[wlog.size()-2], 0);
    chk("wrap_w3", wlog[wlog.size()-1], 1);
    pulse_done();

    // fill the 16 words with events of 5,5,6
    send_evt(5); send_evt(5); send_evt(6);
    wait_neg(3);
    chk("bp_full_ready", s_ready, 0);
    pulse_done();
    @(negedge clk);
    chk("bp_after_done_ready", s_ready, 1);
    @(posedge clk); #1;
    s_valid = 1'b1; s_last = 1'b0; s_data = 32'hB0B0_0005;
    acc_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (s_ready) acc_cnt++;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    chk("bp_accepted", acc_cnt, 5);
    wait_neg(1);
    pulse_done();
    wait_neg(2);
    pulse_done();
    send_evt(1);
    wait_neg(3);
    chk("bp_close_bottom", bottom_addr, 2);
    chk("bp_close_top", top_addr, 7);
    pulse_done();

    // descriptor FIFO full with one-cell events
    repeat (4) send_evt(1);
    wait_neg(3);
    chk("fifo_full_ready", s_ready, 0);
    pulse_done();
    @(negedge clk);
    chk("fifo_pop_ready", s_ready, 1);
    send_evt(1);
    wait_neg(2);
    chk("fifo_refull_ready", s_ready, 0);
    k = 0;
    while (ev_valid && k < 10) begin
      pulse_done();
      @(negedge clk);
      k++;
    end
    chk("fifo_drain_count", k, 4);

    // oversize 20-cell event starting at 13
    base = wlog.size();
    send_evt(20);
    wait_neg(3);
    chk("ovf_flag", overflow, 1);
    chk("ovf_no_ev", ev_valid, 0);
    chk("ovf_writes", wlog.size() - base, 16);
    send_evt(2);
    wait_neg(3);
    chk("ovf_next_bottom", bottom_addr, 13);
    chk("ovf_next_top", top_addr, 14);
    pulse_done();

    // reset in the middle of an open event
    send(0); send(0); send(0);
    @(posedge clk); #1 s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    @(posedge clk); #1 rst_n = 1'b1;
    send_evt(2);
    wait_neg(3);
    chk("postrst_bottom", bottom_addr, 0);
    chk("postrst_top", top_addr, 1);
    chk("postrst_w", wlog[wlog.size()-2], 0);
    pulse_done();
    wait_neg(2);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
